// File: rtl/speccy_kb_pkg.sv
// Shared constants for the Spectrum-matrix to PS/2 set-2 encoder.
// The key table is indexed by row*5+col; bit 8 flags an E0-prefixed (extended) code.
package speccy_kb_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_LOOKUP,
    ST_SEND_EXT,
    ST_SEND_BRK,
    ST_SEND_CODE,
    ST_CLR
  } state_t;

  typedef logic [8:0] key_entry_t;

  localparam key_entry_t KEY_TABLE [40] = '{
    9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A,  // CS Z X C V
    9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,  // A S D F G
    9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,  // Q W E R T
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,  // 1 2 3 4 5
    9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,  // 0 9 8 7 6
    9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,  // P O I U Y
    9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,  // ENT L K J H
    9'h029, 9'h114, 9'h03A, 9'h031, 9'h032   // SPC SS(right Ctrl) M N B
  };

  function automatic logic [2:0] lowest_bit(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/speccy_key_rom.sv
// Combinational matrix-position to {ext, set-2 code} lookup.
// Column positions 5..7 do not exist on the membrane and return zero.
module speccy_key_rom
  import speccy_kb_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  output key_entry_t entry
);

  logic [5:0] idx;

  always_comb begin
    idx   = ({3'b000, row} * 6'd5) + {3'b000, col};
    entry = '0;
    if (col < 3'd5) entry = KEY_TABLE[idx];
  end

endmodule

// File: rtl/speccy_matrix_to_ps2_codes.sv
// Scans an 8x5 Spectrum keyboard matrix, debounces each row and streams PS/2 set-2
// make/break sequences over a valid/ready byte interface.
module speccy_matrix_to_ps2_codes
  import speccy_kb_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] row_sel,
  input  logic [4:0] col_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  logic [2:0]       row_reg;
  logic [4:0]       stable_reg [8];
  logic [4:0]       cand_reg   [8];
  logic [CNT_W-1:0] cnt_reg    [8];
  logic [4:0]       chg_reg;
  logic [2:0]       chg_row_reg;
  logic [2:0]       col_reg;
  key_entry_t       key_reg;
  logic             pressed_reg;

  logic             sample_now;
  logic             accept;
  logic [4:0]       cand_next;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       low_col;
  key_entry_t       rom_entry;
  logic             pressed_now;
  logic [4:0]       chg_left;

  assign row_sel    = ~(8'b0000_0001 << row_reg);
  assign sample_now = (state_reg == ST_SCAN) && (div_reg == DIV_LAST);

  // Debounce arithmetic for the row currently being driven.
  always_comb begin
    cand_next = cand_reg[row_reg];
    cnt_next  = cnt_reg[row_reg];
    if (col_in == cand_reg[row_reg]) begin
      if (cnt_reg[row_reg] != CNT_FULL) cnt_next = cnt_reg[row_reg] + CNT_ONE;
    end else begin
      cand_next = col_in;
      cnt_next  = CNT_ONE;
    end
  end

  assign accept = sample_now && (cnt_next == CNT_FULL) && (cand_next != stable_reg[row_reg]);

  assign low_col     = lowest_bit(chg_reg);
  assign pressed_now = ~cand_reg[chg_row_reg][low_col];
  assign chg_left    = chg_reg & ~(5'b00001 << col_reg);

  speccy_key_rom u_key_rom (
    .row   (chg_row_reg),
    .col   (low_col),
    .entry (rom_entry)
  );

  // Scan divider and row pointer only move while the emitter is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      row_reg <= 3'd0;
    end else if (state_reg == ST_SCAN) begin
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        row_reg <= row_reg + 3'd1;
      end else begin
        div_reg <= div_reg + DIV_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        stable_reg[i] <= 5'h1F;
        cand_reg[i]   <= 5'h1F;
        cnt_reg[i]    <= '0;
      end
    end else begin
      if (sample_now) begin
        cand_reg[row_reg] <= cand_next;
        cnt_reg[row_reg]  <= cnt_next;
      end
      if (state_reg == ST_CLR)
        stable_reg[chg_row_reg][col_reg] <= cand_reg[chg_row_reg][col_reg];
    end
  end

  // Pending-change bookkeeping and the latched key being emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_reg     <= 5'h00;
      chg_row_reg <= 3'd0;
      col_reg     <= 3'd0;
      key_reg     <= '0;
      pressed_reg <= 1'b0;
    end else begin
      if (accept) begin
        chg_reg     <= cand_next ^ stable_reg[row_reg];
        chg_row_reg <= row_reg;
      end
      if (state_reg == ST_LOOKUP) begin
        col_reg     <= low_col;
        key_reg     <= rom_entry;
        pressed_reg <= pressed_now;
      end
      if (state_reg == ST_CLR) chg_reg <= chg_left;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_SCAN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SCAN: begin
        if (accept) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (rom_entry[8])      state_next = ST_SEND_EXT;
        else if (!pressed_now) state_next = ST_SEND_BRK;
        else                   state_next = ST_SEND_CODE;
      end
      ST_SEND_EXT: begin
        if (tx_ready) state_next = pressed_reg ? ST_SEND_CODE : ST_SEND_BRK;
      end
      ST_SEND_BRK: begin
        if (tx_ready) state_next = ST_SEND_CODE;
      end
      ST_SEND_CODE: begin
        if (tx_ready) state_next = ST_CLR;
      end
      ST_CLR: begin
        state_next = (chg_left != 5'h00) ? ST_LOOKUP : ST_SCAN;
      end
      default: state_next = ST_SCAN;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_reg)
      ST_SEND_EXT: begin
        tx_valid = 1'b1;
        tx_data  = PS2_EXT;
      end
      ST_SEND_BRK: begin
        tx_valid = 1'b1;
        tx_data  = PS2_BRK;
      end
      ST_SEND_CODE: begin
        tx_valid = 1'b1;
        tx_data  = key_reg[7:0];
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_speccy_matrix_to_ps2_codes.sv
// Bench: a modelled membrane keyboard drives the scanner; expected byte streams come
// from a key-position table and the make/break framing rules.
module tb_speccy_matrix_to_ps2_codes;

  localparam int SCAN_DIV = 10;
  localparam int DEBOUNCE = 4;
  localparam int SCAN_CYC = 8 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] row_sel;
  logic [4:0] col_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;

  always #5 clk = ~clk;

  speccy_matrix_to_ps2_codes #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_sel  (row_sel),
    .col_in   (col_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Physical keyboard: a held key pulls its column low while its row is driven low.
  logic [4:0] keys_down [8];
  always_comb begin
    col_in = 5'h1F;
    for (int r = 0; r < 8; r++)
      if (!row_sel[r]) col_in = col_in & ~keys_down[r];
  end

  localparam logic [7:0] CODES [8][5] = '{
    '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
  };

  typedef logic [7:0] byte_q_t [$];
  byte_q_t got;
  byte_q_t exp_q;
  int      stamps [$];
  int      cyc = 0;
  int      checks = 0;
  int      failures = 0;
  bit      rand_ready_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      got.push_back(tx_data);
      stamps.push_back(cyc);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready_en) tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void push_key(input int r, input int c, input bit pressed);
    if (r == 7 && c == 1) exp_q.push_back(8'hE0);
    if (!pressed) exp_q.push_back(8'hF0);
    exp_q.push_back(CODES[r][c]);
  endfunction

  // Waits for the expected byte count, lets the bus idle to expose extras, then compares.
  task automatic expect_bytes(input string tag, input int budget);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < budget) begin
      tick(1);
      n++;
    end
    check_value({tag, "_in_time"}, 32'(n < budget), 32'd1);
    tick(2 * SCAN_CYC);
    check_value({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_value($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    $display("txn %-12s expected %0d bytes, received %0d", tag, exp_q.size(), got.size());
  endtask

  task automatic clear_bytes();
    got.delete();
    stamps.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] exp_row;
    logic [7:0] frozen;
    int         n;
    int         r;
    logic [4:0] m;

    for (int i = 0; i < 8; i++) keys_down[i] = 5'h00;

    // Reset state and free-running scan with no keys.
    rst = 1'b1;
    tick(3);
    check_value("rst_row_sel", row_sel, 8'hFE);
    check_value("rst_tx_valid", tx_valid, 1'b0);
    check_value("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 160; k++) begin
      tick(SCAN_DIV);
      exp_row = ~(8'h01 << ((k + 1) % 8));
      check_value($sformatf("scan_row%0d", k), row_sel, exp_row);
    end
    check_value("idle_no_bytes", got.size(), 0);
    clear_bytes();

    // Z press and release.
    keys_down[0][1] = 1'b1;
    push_key(0, 1, 1'b1);
    expect_bytes("z_press", 3000);
    clear_bytes();
    keys_down[0][1] = 1'b0;
    push_key(0, 1, 1'b0);
    expect_bytes("z_release", 3000);
    clear_bytes();

    // Symbol Shift is an extended key; bytes of one key go back-to-back.
    keys_down[7][1] = 1'b1;
    push_key(7, 1, 1'b1);
    expect_bytes("ss_press", 3000);
    if (stamps.size() == 2)
      check_value("ss_press_gap", stamps[1] - stamps[0], 1);
    clear_bytes();
    keys_down[7][1] = 1'b0;
    push_key(7, 1, 1'b0);
    expect_bytes("ss_release", 3000);
    if (stamps.size() == 3) begin
      check_value("ss_rel_gap0", stamps[1] - stamps[0], 1);
      check_value("ss_rel_gap1", stamps[2] - stamps[1], 1);
    end
    clear_bytes();

    // Bouncing Z never settles long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      keys_down[0][1] = (i % 2 == 0);
      tick(SCAN_CYC);
    end
    keys_down[0][1] = 1'b0;
    expect_bytes("z_bounce", 3000);
    clear_bytes();

    // CS+V together with the consumer stalled.
    tx_ready = 1'b0;
    keys_down[0][0] = 1'b1;
    keys_down[0][4] = 1'b1;
    n = 0;
    while (!tx_valid && n < 3000) begin
      tick(1);
      n++;
    end
    check_value("csv_valid_seen", tx_valid, 1'b1);
    frozen = row_sel;
    check_value("csv_row_onehot", $countones(~frozen), 1);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i % 5 == 0) begin
        check_value($sformatf("csv_hold_data%0d", i), tx_data, 8'h12);
        check_value($sformatf("csv_hold_valid%0d", i), tx_valid, 1'b1);
        check_value($sformatf("csv_hold_row%0d", i), row_sel, frozen);
      end
    end
    check_value("csv_nothing_taken", got.size(), 0);
    tx_ready = 1'b1;
    n = 0;
    while (got.size() < 2 && n < 200) begin
      tick(1);
      n++;
    end
    n = 0;
    while (row_sel == frozen && n < SCAN_DIV + 10) begin
      tick(1);
      n++;
    end
    check_value("csv_resume_row", row_sel, {frozen[6:0], frozen[7]});
    push_key(0, 0, 1'b1);
    push_key(0, 4, 1'b1);
    expect_bytes("csv_press", 3000);
    if (stamps.size() == 2)
      check_value("csv_idle_between", 32'((stamps[1] - stamps[0]) >= 2), 32'd1);
    clear_bytes();
    keys_down[0][0] = 1'b0;
    keys_down[0][4] = 1'b0;
    push_key(0, 0, 1'b0);
    push_key(0, 4, 1'b0);
    expect_bytes("csv_release", 3000);
    clear_bytes();

    // Reset aborts an in-flight SS break sequence.
    keys_down[7][1] = 1'b1;
    push_key(7, 1, 1'b1);
    expect_bytes("ss6_press", 3000);
    clear_bytes();
    keys_down[7][1] = 1'b0;
    n = 0;
    while (got.size() < 1 && n < 3000) begin
      tick(1);
      n++;
    end
    rst = 1'b1;
    tx_ready = 1'b0;
    tick(1);
    check_value("abort_tx_valid", tx_valid, 1'b0);
    check_value("abort_row_sel", row_sel, 8'hFE);
    rst = 1'b0;
    tx_ready = 1'b1;
    exp_q.push_back(8'hE0);
    expect_bytes("ss6_abort", 3000);
    clear_bytes();
    expect_bytes("post_reset", 3000);
    clear_bytes();

    // Random single-row changes under random backpressure.
    rand_ready_en = 1'b1;
    for (int t = 0; t < 14; t++) begin
      r = $urandom_range(0, 7);
      m = 5'($urandom_range(1, 31));
      for (int c = 0; c < 5; c++)
        if (m[c]) push_key(r, c, ~keys_down[r][c]);
      keys_down[r] = keys_down[r] ^ m;
      expect_bytes($sformatf("rand%0d_r%0d", t, r), 4000);
      clear_bytes();
    end
    rand_ready_en = 1'b0;
    tick(1);
    tx_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
